// File: rtl/hub75_fb_writein_pkg.sv
// Shared frame-buffer constants for the HUB75 write-in and readout paths:
// word/address widths, {row,col,bank,half} address layout and 24-bit pixel split.
package hub75_fb_writein_pkg;

  localparam int unsigned FB_ADDR_W = 13;
  localparam int unsigned FB_WORD_W = 16;
  localparam int unsigned FB_ROW_W  = 5;
  localparam int unsigned FB_COL_W  = 6;
  localparam int unsigned PIX_PAD_W = 24;
  localparam int unsigned PIX_LO_W  = 16;
  localparam int unsigned PIX_HI_W  = PIX_PAD_W - PIX_LO_W;
  localparam int unsigned CNT_W     = 8;

  typedef struct packed {
    logic [FB_ROW_W-1:0] row;
    logic [FB_COL_W-1:0] col;
    logic                bank;
    logic                half;
  } fb_addr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PEND,
    ST_RUN,
    ST_FLUSH,
    ST_REL
  } wr_state_e;

  // Odd frame-buffer word: upper pixel byte, zero-extended.
  function automatic logic [FB_WORD_W-1:0] fb_hi_word(input logic [PIX_HI_W-1:0] hi);
    return FB_WORD_W'(hi);
  endfunction

endpackage

// File: rtl/hub75_linebuffer.sv
// Staging line RAM: N_WORDS words per address with per-word write mask,
// registered read of the full row of words.
module hub75_linebuffer #(
  parameter int unsigned N_WORDS    = 2,
  parameter int unsigned WORD_WIDTH = 24,
  parameter int unsigned ADDR_WIDTH = 7
) (
  input  logic                          clk,
  input  logic [ADDR_WIDTH-1:0]         wr_addr_i,
  input  logic [WORD_WIDTH-1:0]         wr_data_i,
  input  logic [N_WORDS-1:0]            wr_mask_i,
  input  logic                          wr_ena_i,
  input  logic [ADDR_WIDTH-1:0]         rd_addr_i,
  output logic [N_WORDS*WORD_WIDTH-1:0] rd_data_o,
  input  logic                          rd_ena_i
);

  logic [N_WORDS-1:0][WORD_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [N_WORDS-1:0][WORD_WIDTH-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (wr_ena_i) begin
      for (int w = 0; w < int'(N_WORDS); w++) begin
        if (wr_mask_i[w]) mem_q[wr_addr_i][w] <= wr_data_i;
      end
    end
    if (rd_ena_i) rd_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/hub75_fb_writein.sv
// Row-commit writer: double-buffered staging line committed to one frame-buffer row
// through the shared arbiter. HUB75_FB_WRITEIN_DIRTY_EN enables per-half dirty bitmaps.
module hub75_fb_writein
  import hub75_fb_writein_pkg::*;
#(
  parameter int unsigned N_BANKS     = 2,
  parameter int unsigned N_ROWS      = 32,
  parameter int unsigned N_COLS      = 64,
  parameter int unsigned N_CHANS     = 3,
  parameter int unsigned N_PLANES    = 8,
  parameter int unsigned LOG_N_BANKS = $clog2(N_BANKS),
  parameter int unsigned LOG_N_ROWS  = $clog2(N_ROWS),
  parameter int unsigned LOG_N_COLS  = $clog2(N_COLS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [LOG_N_ROWS-1:0]         wr_row_addr,
  input  logic                          wr_row_store,
  output logic                          wr_row_rdy,
  input  logic                          wr_row_swap,
  input  logic [N_CHANS*N_PLANES-1:0]   wr_data,
  input  logic [LOG_N_COLS-1:0]         wr_col_addr,
  input  logic [LOG_N_BANKS-1:0]        wr_bank_addr,
  input  logic                          wr_en,
  output logic                          ctrl_req,
  input  logic                          ctrl_gnt,
  output logic                          ctrl_rel,
  output logic [FB_ADDR_W-1:0]          fb_addr,
  output logic [FB_WORD_W-1:0]          fb_data,
  output logic                          fb_wren
);

  localparam int unsigned PIX_W = N_CHANS * N_PLANES;
  localparam int unsigned LB_AW = 1 + LOG_N_COLS;

  wr_state_e              state_q, state_d;
  logic                   buf_q, buf_d;
  logic [LOG_N_ROWS-1:0]  row_q, row_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [PIX_HI_W-1:0]    pix_hi_q, pix_hi_d;
  logic                   rdy_q, rdy_d;
  logic                   req_q, req_d;
  logic                   rel_q, rel_d;
  logic                   wren_q, wren_d;
  fb_addr_t               addr_q, addr_d;
  logic [FB_WORD_W-1:0]   data_q, data_d;

  logic [N_BANKS-1:0][PIX_W-1:0] lb_rd_data;
  logic [PIX_W-1:0]              rd_word_c;
  logic [PIX_PAD_W-1:0]          rd_pad_c;
  logic                          pix_dirty_c;

  // Host writes land in half buf; the commit reads half ~buf one count ahead.
  hub75_linebuffer #(
    .N_WORDS   (N_BANKS),
    .WORD_WIDTH(PIX_W),
    .ADDR_WIDTH(LB_AW)
  ) u_stage (
    .clk      (clk),
    .wr_addr_i({buf_q, wr_col_addr}),
    .wr_data_i(wr_data),
    .wr_mask_i(N_BANKS'(1) << wr_bank_addr),
    .wr_ena_i (wr_en),
    .rd_addr_i({~buf_q, cnt_d[7:2]}),
    .rd_data_o(lb_rd_data),
    .rd_ena_i (1'b1)
  );

  assign rd_word_c = lb_rd_data[cnt_q[1]];
  assign rd_pad_c  = PIX_PAD_W'(rd_word_c);

`ifdef HUB75_FB_WRITEIN_DIRTY_EN
  localparam int unsigned PIX_IDX_W = LOG_N_COLS + LOG_N_BANKS;

  logic [2*N_BANKS*N_COLS-1:0] dirty_q, dirty_d;

  always_comb begin
    dirty_d = dirty_q;
    if (state_q == ST_REL) begin
      for (int i = 0; i < int'(N_BANKS * N_COLS); i++) begin
        dirty_d[{~buf_q, PIX_IDX_W'(i)}] = 1'b0;
      end
    end
    if (wr_en) dirty_d[{buf_q, wr_col_addr, wr_bank_addr}] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) dirty_q <= '0;
    else        dirty_q <= dirty_d;
  end

  assign pix_dirty_c = dirty_q[{~buf_q, cnt_q[7:1]}];
`else
  assign pix_dirty_c = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    pix_hi_d = pix_hi_q;
    addr_d   = addr_q;
    data_d   = data_q;
    wren_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_row_swap) buf_d = ~buf_q;
        if (wr_row_store) begin
          row_d   = wr_row_addr;
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (ctrl_gnt) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_d  = cnt_q + CNT_W'(1);
        wren_d = pix_dirty_c;
        addr_d = '{row: FB_ROW_W'(row_q), col: cnt_q[7:2], bank: cnt_q[1], half: cnt_q[0]};
        // Even count consumes the fresh read; odd count uses the held upper byte.
        if (!cnt_q[0]) begin
          data_d   = rd_pad_c[PIX_LO_W-1:0];
          pix_hi_d = rd_pad_c[PIX_PAD_W-1:PIX_LO_W];
        end else begin
          data_d = fb_hi_word(pix_hi_q);
        end
        if (cnt_q == '1) state_d = ST_FLUSH;
      end
      ST_FLUSH: state_d = ST_REL;
      ST_REL:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    rdy_d = (state_d == ST_IDLE);
    req_d = (state_d == ST_PEND);
    rel_d = (state_d == ST_REL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      buf_q    <= 1'b0;
      row_q    <= '0;
      cnt_q    <= '0;
      pix_hi_q <= '0;
      rdy_q    <= 1'b1;
      req_q    <= 1'b0;
      rel_q    <= 1'b0;
      wren_q   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      row_q    <= row_d;
      cnt_q    <= cnt_d;
      pix_hi_q <= pix_hi_d;
      rdy_q    <= rdy_d;
      req_q    <= req_d;
      rel_q    <= rel_d;
      wren_q   <= wren_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign wr_row_rdy = rdy_q;
  assign ctrl_req   = req_q;
  assign ctrl_rel   = rel_q;
  assign fb_wren    = wren_q;
  assign fb_addr    = addr_q;
  assign fb_data    = data_q;

endmodule

// File: doc/hub75_fb_writein.md
# hub75_fb_writein

Row-commit writer into the HUB75 frame buffer: the write-side counterpart of the frame-buffer-to-line-buffer readout path. A host fills a double-buffered staging line (N_BANKS × N_COLS pixels, N_CHANS × N_PLANES bits each), swaps halves, then commits the filled half to a chosen frame-buffer row. The commit runs through the shared frame-buffer arbiter (req/gnt/rel) and emits 16-bit frame-buffer word writes in the same address layout the display readout consumes.

## Interface
- N_BANKS, 2, panel banks; frame-buffer layout fixed for 2
- N_ROWS, 32, rows per bank
- N_COLS, 64, columns
- N_CHANS, 3, colour channels
- N_PLANES, 8, bits per channel; N_CHANS*N_PLANES ≤ 32
- LOG_N_BANKS / LOG_N_ROWS / LOG_N_COLS, $clog2 of above, auto-set
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- wr_row_addr  in  LOG_N_ROWS  target row, sampled with wr_row_store
- wr_row_store  in  1  pulse: commit staged half to wr_row_addr
- wr_row_rdy  out  1  idle; store and swap accepted
- wr_row_swap  in  1  pulse: exchange host/commit halves
- wr_data  in  N_CHANS*N_PLANES  pixel
- wr_col_addr  in  LOG_N_COLS  pixel column
- wr_bank_addr  in  LOG_N_BANKS  pixel bank
- wr_en  in  1  pixel write strobe into host half
- ctrl_req  out  1  arbiter request
- ctrl_gnt  in  1  one-cycle grant pulse
- ctrl_rel  out  1  one-cycle release pulse
- fb_addr  out  13  {row, col[5:0], bank, half}
- fb_data  out  16  word data
- fb_wren  out  1  word write enable

## Operation
- buf bit: host writes to half buf; commit reads half ~buf. Swap toggles buf only when wr_row_rdy=1; otherwise ignored.
- Store with wr_row_rdy=1: latch row, set pending, drop wr_row_rdy next cycle. Store while busy ignored.
- Store and swap same cycle: swap applies; commit uses newly retired half.
- pending drives ctrl_req; cleared on ctrl_gnt. gnt sets running; 8-bit cnt runs 0..255 while running, then stops.
- cnt even: read staging at {~buf, cnt[7:2], cnt[1]} (col, bank).
- Word split per pixel P (zero-padded to 24 bits): half 0 = P[15:0], half 1 = {8'h00, P[23:16]}; bits above 24 are ignored.
- Pixel register holds the read result for the odd word.
- After the last write: ctrl_rel pulse, running cleared, wr_row_rdy=1.
- wr_en writes the host half at all times, including during a commit.

## Timing
- Reset values: wr_row_rdy=1, ctrl_req=0, ctrl_rel=0, fb_wren=0, fb_addr=0, fb_data=0, buf=0, cnt=0.
- Reset mid-commit aborts silently; no ctrl_rel (arbiter shares reset).
- Store at cycle S → ctrl_req high at S+1.
- Grant sampled at G → running at G+1, cnt=0 at G+1, cnt=255 at G+256.
- fb_wren high G+2..G+257 (256 words); fb_addr low byte = cnt delayed 1.
- ctrl_rel at G+258; ctrl_req low from G+1; wr_row_rdy high at G+259.
- Staging read latency 1 cycle; pixel write visible to a commit that starts the following cycle.

## Configuration
- HUB75_FB_WRITEIN_DIRTY_EN defined: per-half dirty bitmap (N_BANKS*N_COLS bits); wr_en sets a bit; commit asserts fb_wren only for dirty pixels (both words); the committed half's bitmap clears at ctrl_rel. Address, timing and rel unchanged.
- Undefined: no bitmap; all 256 words written every commit.

## Structure
- Shared package constants: frame-buffer address width (13), word width (16), field order {row,col,bank,half}, 24-bit pixel split points; shared with the readout path.
- Sub-module: staging RAM is an instance of hub75_linebuffer (N_WORDS=N_BANKS, WORD_WIDTH=N_CHANS*N_PLANES, ADDR_WIDTH=1+LOG_N_COLS); wr_bank_addr is decoded to its one-hot mask. Control, counter and word split stay in this module.

## Test plan
- Fill col c, bank b with 24'h{c,b,A5}; swap; store row 5; gnt 3 cycles later → 256 writes, addr {5,c,b,0}=16'h{b,A5}, {5,c,b,1}=16'h00{c}; ctrl_rel at G+258.
- Store, withhold gnt 100 cycles → ctrl_req held high, fb_wren=0, second store and swap ignored.
- Swap and store same cycle → committed data equals half filled before the swap.
- rst_n low at G+100 → next cycle fb_wren=0, ctrl_req=0, wr_row_rdy=1, no ctrl_rel.
- Host writes col 0 with 24'hFFFFFF during commit → fb output unchanged from pre-swap data.
- DIRTY_EN: write only col 7 bank 1 → exactly 2 fb_wren cycles (addr {row,7,1,0/1}); second commit of same half → 0 writes.
